// File: rtl/dual_clcg_prng.sv
// Dual linear congruential PRNG: the bit z = (x_next > y_next) is produced each RUN cycle,
// and the bits are packed MSB-first into words that leave on a valid/ready handshake.
module dual_clcg_prng #(
    parameter int unsigned W     = 8,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [W-1:0]     seed_x,
    input  logic [W-1:0]     seed_y,
    input  logic [W-1:0]     a1,
    input  logic [W-1:0]     b1,
    input  logic [W-1:0]     a2,
    input  logic [W-1:0]     b2,
    output logic [OUT_W-1:0] rand_word,
    output logic             rand_valid,
    input  logic             rand_ready,
    output logic             busy,
    output logic             bit_out
);

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(OUT_W);

    state_e             state_q, state_d;
    logic [W-1:0]       x_q, x_d, y_q, y_d;
    logic [W-1:0]       a1_q, a1_d, b1_q, b1_d, a2_q, a2_d, b2_q, b2_d;
    logic [OUT_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   rand_word_q, rand_word_d;
    logic               rand_valid_q, rand_valid_d;
    logic               busy_q, busy_d;
    logic               bit_out_q, bit_out_d;

    logic [W-1:0]       x_nxt, y_nxt;
    logic               z;
    logic [OUT_W-1:0]   shift_nxt;
    logic               xfer;

    // One LCG step for each generator; the multiply is truncated to W bits, which gives mod 2^W.
    always_comb begin
        x_nxt     = W'(a1_q * x_q + b1_q);
        y_nxt     = W'(a2_q * y_q + b2_q);
        z         = (x_nxt > y_nxt);
        shift_nxt = {shift_q[OUT_W-2:0], z};
        xfer      = rand_valid_q & rand_ready;
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        a1_d         = a1_q;
        b1_d         = b1_q;
        a2_d         = a2_q;
        b2_d         = b2_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        rand_word_d  = rand_word_q;
        rand_valid_d = rand_valid_q;
        bit_out_d    = bit_out_q;

        case (state_q)
            IDLE: begin
                if (xfer) rand_valid_d = 1'b0;
                if (start) begin
                    x_d     = seed_x;
                    y_d     = seed_y;
                    a1_d    = a1;
                    b1_d    = b1;
                    a2_d    = a2;
                    b2_d    = b2;
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (xfer) rand_valid_d = 1'b0;
                if (stop) begin
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    x_d       = x_nxt;
                    y_d       = y_nxt;
                    shift_d   = shift_nxt;
                    bit_out_d = z;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        if (!rand_valid_q || rand_ready) begin
                            rand_word_d  = shift_nxt;
                            rand_valid_d = 1'b1;
                            cnt_d        = '0;
                        end else begin
                            // Slot occupied: park the finished word in the shift register.
                            cnt_d   = CNT_SAT;
                            state_d = STALL;
                        end
                    end
                end
            end
            STALL: begin
                if (stop) begin
                    if (xfer) rand_valid_d = 1'b0;
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (rand_ready) begin
                    rand_word_d  = shift_q;
                    rand_valid_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            a1_q         <= '0;
            b1_q         <= '0;
            a2_q         <= '0;
            b2_q         <= '0;
            shift_q      <= '0;
            cnt_q        <= '0;
            rand_word_q  <= '0;
            rand_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            bit_out_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            a1_q         <= a1_d;
            b1_q         <= b1_d;
            a2_q         <= a2_d;
            b2_q         <= b2_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            rand_word_q  <= rand_word_d;
            rand_valid_q <= rand_valid_d;
            busy_q       <= busy_d;
            bit_out_q    <= bit_out_d;
        end
    end

    assign rand_word  = rand_word_q;
    assign rand_valid = rand_valid_q;
    assign busy       = busy_q;
    assign bit_out    = bit_out_q;

endmodule

// File: tb/tb_dual_clcg_prng.sv
// Bench for dual_clcg_prng: a W=4/OUT_W=4 instance for the handshake, stall and stop scenarios,
// and a W=8/OUT_W=8 instance for the wrap-around case, both checked against an arithmetic model.
module tb_dual_clcg_prng;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk1 = ~clk1;

    logic       start4 = 1'b0, stop4 = 1'b0, ready4 = 1'b0;
    logic [3:0] sx4 = '0, sy4 = '0, a14 = '0, b14 = '0, a24 = '0, b24 = '0;
    logic [3:0] word4;
    logic       valid4, busy4, bit4;

    logic       start8 = 1'b0, stop8 = 1'b0, ready8 = 1'b0;
    logic [7:0] sx8 = '0, sy8 = '0, a18 = '0, b18 = '0, a28 = '0, b28 = '0;
    logic [7:0] word8;
    logic       valid8, busy8, bit8;

    dual_clcg_prng #(.W(4), .OUT_W(4), .CNT_W(3)) dut4 (
        .clk1(clk1), .rst(rst), .start(start4), .stop(stop4),
        .seed_x(sx4), .seed_y(sy4), .a1(a14), .b1(b14), .a2(a24), .b2(b24),
        .rand_word(word4), .rand_valid(valid4), .rand_ready(ready4),
        .busy(busy4), .bit_out(bit4)
    );

    dual_clcg_prng #(.W(8), .OUT_W(8), .CNT_W(4)) dut8 (
        .clk1(clk1), .rst(rst), .start(start8), .stop(stop8),
        .seed_x(sx8), .seed_y(sy8), .a1(a18), .b1(b18), .a2(a28), .b2(b28),
        .rand_word(word8), .rand_valid(valid8), .rand_ready(ready8),
        .busy(busy8), .bit_out(bit8)
    );

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int exp_bits[$];

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    // Reference: step both generators with plain integer arithmetic, emitting bits and packed words.
    task automatic build_exp(input int w, input int ow, input int sx, input int sy,
                             input int ca1, input int cb1, input int ca2, input int cb2,
                             input int nwords);
        int m = (1 << w) - 1;
        int x = sx;
        int y = sy;
        int word;
        int zb;
        exp_q.delete();
        exp_bits.delete();
        for (int k = 0; k < nwords; k++) begin
            word = 0;
            for (int i = 0; i < ow; i++) begin
                x = (ca1 * x + cb1) & m;
                y = (ca2 * y + cb2) & m;
                zb = (x > y) ? 1 : 0;
                exp_bits.push_back(zb);
                word = (word << 1) | zb;
            end
            exp_q.push_back(word);
        end
    endtask

    task automatic set_cfg4(input int sx, input int ca1, input int cb1,
                            input int sy, input int ca2, input int cb2);
        sx4 = 4'(sx); a14 = 4'(ca1); b14 = 4'(cb1);
        sy4 = 4'(sy); a24 = 4'(ca2); b24 = 4'(cb2);
    endtask

    // Start, then run nw words with rand_ready=1, checking every bit and each word boundary.
    task automatic run_words4(input int nw, input bit perturb);
        logic [3:0] s_sx = sx4, s_sy = sy4, s_a1 = a14, s_b1 = b14, s_a2 = a24, s_b2 = b24;
        int bi = 0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int w = 0; w < nw; w++) begin
            for (int i = 0; i < 4; i++) begin
                if (perturb) begin
                    sx4 = 4'($urandom); a14 = 4'($urandom); b14 = 4'($urandom);
                    sy4 = 4'($urandom); a24 = 4'($urandom); b24 = 4'($urandom);
                    start4 = 1'($urandom_range(0, 1));
                end
                tick();
                check("bit_out", int'(bit4), exp_bits[bi]);
                bi++;
                check("busy_run", int'(busy4), 1);
                if (i == 3) begin
                    check("word_valid", int'(valid4), 1);
                    check("word", int'(word4), exp_q[w]);
                end else begin
                    check("no_valid", int'(valid4), 0);
                end
            end
        end
        start4 = 1'b0;
        sx4 = s_sx; sy4 = s_sy; a14 = s_a1; b14 = s_b1; a24 = s_a2; b24 = s_b2;
    endtask

    task automatic stop4_and_drain();
        stop4 = 1'b1;
        tick();
        stop4 = 1'b0;
        check("stop_busy", int'(busy4), 0);
        ready4 = 1'b1;
        tick();
        tick();
        check("drained", int'(valid4), 0);
    endtask

    initial begin
        int pv, pw, pr, nx;

        #1 rst = 1'b0;
        #2;
        check("rst_word4", int'(word4), 0);
        check("rst_valid4", int'(valid4), 0);
        check("rst_busy4", int'(busy4), 0);
        check("rst_bit4", int'(bit4), 0);
        check("rst_valid8", int'(valid8), 0);
        @(negedge clk1);
        rst = 1'b1;

        // Directed sequence with an always-ready consumer.
        set_cfg4(3, 5, 1, 2, 3, 7);
        build_exp(4, 4, 3, 2, 5, 1, 3, 7, 64);
        ready4 = 1'b1;
        tick();
        run_words4(2, 1'b0);
        check("word_0xD", int'(word4), 'hD);
        stop4_and_drain();

        // Backpressure: the second word stalls the generators until the consumer takes the first.
        ready4 = 1'b0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (4) tick();
        check("stall_w0_valid", int'(valid4), 1);
        check("stall_w0", int'(word4), 'h3);
        repeat (4) tick();
        check("stall_busy", int'(busy4), 1);
        check("stall_word_held", int'(word4), 'h3);
        check("stall_bit", int'(bit4), exp_bits[7]);
        repeat (3) tick();
        check("stall_bit_frozen", int'(bit4), exp_bits[7]);
        check("stall_valid_held", int'(valid4), 1);
        ready4 = 1'b1;
        tick();
        ready4 = 1'b0;
        check("resume_word", int'(word4), exp_q[1]);
        check("resume_valid", int'(valid4), 1);
        tick();
        check("resume_bit_x8", int'(bit4), exp_bits[8]);
        repeat (3) tick();
        check("stall2_busy", int'(busy4), 1);
        check("stall2_word", int'(word4), exp_q[1]);
        ready4 = 1'b1;
        tick();
        check("stall2_release", int'(word4), exp_q[2]);
        stop4_and_drain();

        // Stop two bits into the second word: pending word survives, restart reproduces.
        ready4 = 1'b0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (6) tick();
        stop4 = 1'b1;
        tick();
        stop4 = 1'b0;
        check("stop_idle", int'(busy4), 0);
        check("stop_pending_valid", int'(valid4), 1);
        check("stop_pending_word", int'(word4), 'h3);
        repeat (2) tick();
        check("idle_no_activity", int'(word4), 'h3);
        ready4 = 1'b1;
        tick();
        check("pending_taken", int'(valid4), 0);
        run_words4(2, 1'b0);
        stop4_and_drain();

        // Coefficient/seed churn and start pulses while busy must not disturb the sequence.
        run_words4(3, 1'b1);
        stop4_and_drain();

        // Asynchronous reset between edges.
        ready4 = 1'b0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (5) tick();
        check("pre_arst_valid", int'(valid4), 1);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", int'(busy4), 0);
        check("arst_valid", int'(valid4), 0);
        check("arst_word", int'(word4), 0);
        check("arst_bit", int'(bit4), 0);
        @(negedge clk1);
        rst = 1'b1;
        repeat (5) tick();
        check("post_arst_busy", int'(busy4), 0);
        check("post_arst_valid", int'(valid4), 0);

        // Randomised configurations and consumer readiness, scored in transfer order.
        for (int t = 0; t < 4; t++) begin
            set_cfg4(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            build_exp(4, 4, int'(sx4), int'(sy4), int'(a14), int'(b14),
                      int'(a24), int'(b24), 80);
            nx = 0;
            start4 = 1'b1;
            tick();
            start4 = 1'b0;
            for (int c = 0; c < 200; c++) begin
                ready4 = 1'($urandom_range(0, 1));
                pv = int'(valid4);
                pw = int'(word4);
                pr = int'(ready4);
                tick();
                if (pv == 1 && pr == 1) begin
                    if (exp_q.size() == 0) check("sb_underflow", 1, 0);
                    else check("sb_xfer", pw, exp_q.pop_front());
                    nx++;
                end else if (pv == 1) begin
                    check("sb_hold_valid", int'(valid4), 1);
                    check("sb_hold_word", int'(word4), pw);
                end
            end
            check("sb_enough_xfers", (nx >= 20) ? 1 : 0, 1);
            stop4_and_drain();
        end

        // W=8: x wraps from 255, y stuck at 0.
        sx8 = 8'd255; sy8 = 8'd0; a18 = 8'd1; b18 = 8'd1; a28 = 8'd1; b28 = 8'd0;
        build_exp(8, 8, 255, 0, 1, 1, 1, 0, 2);
        ready8 = 1'b1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("w8_bit", int'(bit8), exp_bits[i]);
            if (i < 7) check("w8_no_valid", int'(valid8), 0);
        end
        check("w8_valid", int'(valid8), 1);
        check("w8_word_model", int'(word8), exp_q[0]);
        check("w8_word_0x7F", int'(word8), 'h7F);
        check("w8_busy", int'(busy8), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dual_clcg_prng.md
Name: dual_clcg_prng

Overview:
- Parametrised successor to the single 4-bit LCG: two W-bit linear congruential generators (x, y) run in lockstep on one clock.
- Each step emits one random bit, z = (x_next > y_next).
- Bits are packed MSB-first into OUT_W-bit words, delivered on a valid/ready handshake with backpressure.
- Sits between the seed/coefficient configuration logic and downstream consumers of random words.

Parameters:
- W, 8, LCG state/coefficient width; modulus fixed at 2^W.
- OUT_W, 8, bits per output word (>=2).
- CNT_W, 4, width of bit counter; must satisfy 2^CNT_W > OUT_W.

Ports:
- clk1  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level, sampled in IDLE: load seeds/coefficients and begin generation.
- stop  in  1  level, sampled in RUN/STALL: abort to IDLE.
- seed_x  in  W  initial x.
- seed_y  in  W  initial y.
- a1, b1  in  W each  multiplier/increment of LCG x.
- a2, b2  in  W each  multiplier/increment of LCG y.
- rand_word  out  OUT_W  packed random word.
- rand_valid  out  1  rand_word holds an unconsumed word.
- rand_ready  in  1  consumer accepts rand_word.
- busy  out  1  high in RUN or STALL.
- bit_out  out  1  most recent z bit (debug/serial tap).

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; x, y, latched coefficients, shift register, bit counter, rand_word, bit_out = 0; rand_valid=0; busy=0.
- States: IDLE, RUN, STALL.
- IDLE & start: on that edge, x<=seed_x, y<=seed_y, a1/b1/a2/b2 captured into internal registers, counter<=0, -> RUN. Coefficient inputs are ignored until the next IDLE->RUN transition.
- Each RUN cycle advances both LCGs:
  - x<=(a1*x+b1) mod 2^W; y<=(a2*y+b2) mod 2^W. Full product, truncated to W bits; no carry retained.
  - z=(x_next>y_next), unsigned compare.
  - z is shifted into the shift register LSB, shifting left; bit_out<=z; counter++.
- Word completion, on the RUN cycle the counter reaches OUT_W-1:
  - If the output slot is free (rand_valid=0, or rand_valid&rand_ready this cycle): rand_word<={shift[OUT_W-2:0],z}, rand_valid<=1, counter<=0, stay RUN.
  - Otherwise the completed word is held in the shift register, counter saturates at OUT_W, -> STALL.
- STALL: x, y, and counter frozen; bit_out held. When rand_ready is high, the held word moves to rand_word the same edge (rand_valid stays 1), counter<=0, -> RUN.
- Handshake: transfer occurs on an edge with rand_valid&rand_ready. rand_valid falls after a transfer unless a new word is loaded on the same edge. rand_word is stable while rand_valid=1 and not transferred.
- First word latency: start sampled at edge k, so rand_valid rises after edge k+OUT_W when unstalled. Sustained throughput is one word per OUT_W cycles.
- stop in RUN/STALL: -> IDLE next edge; partial/held shift-register bits discarded, counter<=0. A word already in rand_word stays valid until consumed. stop has priority over word completion on the same edge.
- start while busy: ignored. start and stop both high in IDLE: start wins.
- busy=1 exactly in RUN/STALL.
- Wrap-around: state values wrap mod 2^W with no special handling. Degenerate coefficients (even a, b=0) are permitted and are not flagged.

Test Plan:
- W=4, OUT_W=4, seed_x=3, a1=5, b1=1, seed_y=2, a2=3, b2=7, rand_ready=1, pulse start -> x seq 0,1,6,15,12,13,2,11; y seq 13,14,1,10,5,6,9,2; z seq 0,0,1,1,1,1,0,1; words 0x3 then 0xD; rand_valid first rises 4 edges after start edge.
- Same setup, rand_ready=0 -> after word 0x3, second word completes and state=STALL with x=11, y=2 frozen. Raise rand_ready for one cycle -> 0x3 transferred, 0xD loaded, RUN resumes with x->(5*11+1) mod 16=8.
- Assert stop 2 cycles into the second word -> IDLE, busy=0, pending 0x3 still valid. Restart with same seeds -> words 0x3, 0xD reproduced.
- Drive rst low asynchronously mid-RUN (between edges) -> all outputs 0 immediately, without waiting for a clk1 edge. After release, no activity until start.
- Change a1/b1 while RUN -> sequence unchanged from captured values. start pulsed while busy -> no reload.
- W=8, OUT_W=8, a1=a2=1, b1=1, b2=0, seed_x=255, seed_y=0 -> x wraps 0,1,2..., y stays 0. z seq 0,1,1,1,1,1,1,1; first word 0x7F.
